// File: rtl/free_list_ctrl_pkg.sv
// Shared free-list constants and types for rename, retire and the branch stack.
package free_list_ctrl_pkg;

  localparam int unsigned SS_WIDTH         = 3;   // superscalar width
  localparam int unsigned PHYS_REG_SZ_R10K = 64;  // physical register count
  localparam int unsigned ARCH_REG_SZ      = 32;  // architectural register count
  localparam int unsigned BR_CKPTS         = 4;   // branch stack depth

  localparam int unsigned PHYS_REG_IDX_W = $clog2(PHYS_REG_SZ_R10K);
  localparam int unsigned FL_PTR_W       = PHYS_REG_IDX_W + 1;
  localparam int unsigned CKPT_IDX_W     = $clog2(BR_CKPTS);

  typedef logic [PHYS_REG_IDX_W-1:0] phys_reg_idx_t;
  typedef logic [FL_PTR_W-1:0]       fl_ptr_t;
  typedef logic [CKPT_IDX_W-1:0]     ckpt_idx_t;

endpackage

// File: rtl/free_list_ctrl_retire_compactor.sv
// Packs the valid retire slots into a dense array in slot order and counts them.
module free_list_ctrl_retire_compactor
  import free_list_ctrl_pkg::*;
#(
  parameter int unsigned N    = SS_WIDTH,
  parameter int unsigned W    = PHYS_REG_IDX_W,
  parameter int unsigned CntW = $clog2(N + 1)
) (
  input  logic [N-1:0]        valid_i,
  input  logic [N-1:0][W-1:0] data_i,
  output logic [N-1:0][W-1:0] dense_o,
  output logic [CntW-1:0]     count_o
);

  // Running count doubles as the write index into the dense array.
  always_comb begin
    dense_o = '0;
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      if (valid_i[i]) begin
        dense_o[count_o] = data_i[i];
        count_o          = count_o + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/free_list_ctrl.sv
// Physical-register free list: circular buffer with N-wide allocate and free,
// plus head checkpoints for branch mispredict recovery.
module free_list_ctrl
  import free_list_ctrl_pkg::*;
#(
  parameter int unsigned N         = SS_WIDTH,
  parameter int unsigned DEPTH     = PHYS_REG_SZ_R10K,
  parameter int unsigned ARCH_REGS = ARCH_REG_SZ,
  parameter int unsigned CKPTS     = BR_CKPTS,
  localparam int unsigned IdxW     = $clog2(DEPTH),
  localparam int unsigned PtrW     = IdxW + 1,
  localparam int unsigned CntW     = $clog2(N + 1),
  localparam int unsigned FreeW    = $clog2(DEPTH + 1),
  localparam int unsigned CkptW    = $clog2(CKPTS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N-1:0]           retire_valid,
  input  logic [N-1:0][IdxW-1:0] retire_reg,
  input  logic [CntW-1:0]        num_requested,
  output logic [CntW-1:0]        num_granted,
  output logic [N-1:0][IdxW-1:0] regs_to_use,
  output logic [FreeW-1:0]       num_free,
  input  logic                   ckpt_save,
  input  logic [CkptW-1:0]       ckpt_save_id,
  input  logic                   ckpt_restore,
  input  logic [CkptW-1:0]       ckpt_restore_id
);

  logic [IdxW-1:0] fl_buf_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [PtrW-1:0] ckpt_q [CKPTS];

  logic [PtrW-1:0]         free_w;
  logic [PtrW-1:0]         head_alloc;
  logic [N-1:0][IdxW-1:0]  dense;
  logic [CntW-1:0]         free_cnt;

  free_list_ctrl_retire_compactor #(
    .N    (N),
    .W    (IdxW),
    .CntW (CntW)
  ) u_compactor (
    .valid_i (retire_valid),
    .data_i  (retire_reg),
    .dense_o (dense),
    .count_o (free_cnt)
  );

  // Full-width subtract; the wrap bit separates full from empty.
  assign free_w   = tail_q - head_q;
  assign num_free = FreeW'(free_w);

  // Grant min(requested, free); suppressed during reset and recovery.
  always_comb begin
    num_granted = num_requested;
    if (!reset || ckpt_restore) begin
      num_granted = '0;
    end else if (PtrW'(num_requested) > free_w) begin
      num_granted = CntW'(free_w);
    end
  end

  // Read ports: the next N entries starting at head.
  always_comb begin
    regs_to_use = '0;
    for (int i = 0; i < N; i++) begin
      regs_to_use[i] = fl_buf_q[head_q[IdxW-1:0] + IdxW'(i)];
    end
  end

  // Pointer next-state; same-cycle frees never feed this cycle's grant.
  always_comb begin
    head_alloc = head_q + PtrW'(num_granted);
    head_d     = ckpt_restore ? ckpt_q[ckpt_restore_id] : head_alloc;
    tail_d     = tail_q + PtrW'(free_cnt);
  end

  // Head, tail and checkpoint registers; restore wins over a same-cycle save.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= PtrW'(DEPTH - ARCH_REGS);
      for (int c = 0; c < CKPTS; c++) begin
        ckpt_q[c] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (ckpt_save && !ckpt_restore) begin
        ckpt_q[ckpt_save_id] <= head_alloc;
      end
    end
  end

  // Buffer RAM: reset loads the unmapped regs, frees append densely at tail.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fl_buf_q[i] <= (i < int'(DEPTH - ARCH_REGS)) ? IdxW'(ARCH_REGS + i) : '0;
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        if (CntW'(j) < free_cnt) begin
          fl_buf_q[tail_q[IdxW-1:0] + IdxW'(j)] <= dense[j];
        end
      end
    end
  end

  // Retire must never push more regs than the buffer can hold.
  assert property (@(posedge clock) disable iff (!reset)
    ({1'b0, free_w} + (PtrW + 1)'(free_cnt)) <= (PtrW + 1)'(DEPTH));

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed bench for free_list_ctrl (N=3, DEPTH=64, ARCH_REGS=32, CKPTS=4).
module tb_free_list_ctrl;

  logic            clock = 1'b0;
  logic            reset;
  logic [2:0]      retire_valid;
  logic [2:0][5:0] retire_reg;
  logic [1:0]      num_requested;
  logic [1:0]      num_granted;
  logic [2:0][5:0] regs_to_use;
  logic [6:0]      num_free;
  logic            ckpt_save;
  logic [1:0]      ckpt_save_id;
  logic            ckpt_restore;
  logic [1:0]      ckpt_restore_id;

  int checks = 0;
  int errors = 0;

  free_list_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .retire_valid    (retire_valid),
    .retire_reg      (retire_reg),
    .num_requested   (num_requested),
    .num_granted     (num_granted),
    .regs_to_use     (regs_to_use),
    .num_free        (num_free),
    .ckpt_save       (ckpt_save),
    .ckpt_save_id    (ckpt_save_id),
    .ckpt_restore    (ckpt_restore),
    .ckpt_restore_id (ckpt_restore_id)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic [1:0] req, input logic [2:0] rv,
                        input logic [5:0] r0, input logic [5:0] r1, input logic [5:0] r2);
    num_requested = req;
    retire_valid  = rv;
    retire_reg[0] = r0;
    retire_reg[1] = r1;
    retire_reg[2] = r2;
  endtask

  task automatic idle();
    set_in(2'd0, 3'b000, 6'd0, 6'd0, 6'd0);
    ckpt_save    = 1'b0;
    ckpt_restore = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    ckpt_save_id = 2'd0; ckpt_restore_id = 2'd0;
    reset = 1'b0;
    num_requested = 2'd3;
    tick(); tick();
    checks++; if (num_granted !== 2'd0) begin errors++;
      $display("FAIL reset_grant: got %0d expected 0", num_granted); end
    reset = 1'b1;
    num_requested = 2'd0;
    #1;
    checks++; if (num_free !== 7'd32) begin errors++;
      $display("FAIL reset_free: got %0d expected 32", num_free); end
    checks++; if (num_granted !== 2'd0) begin errors++;
      $display("FAIL reset_nogrant: got %0d expected 0", num_granted); end
  endtask

  task automatic test_alloc();
    set_in(2'd3, 3'b000, 6'd0, 6'd0, 6'd0);
    #1;
    checks++; if (num_granted !== 2'd3) begin errors++;
      $display("FAIL alloc_grant: got %0d expected 3", num_granted); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (regs_to_use[i] !== 6'(32 + i)) begin errors++;
        $display("FAIL alloc_reg%0d: got %0d expected %0d", i, regs_to_use[i], 32 + i); end
    end
    tick();
    num_requested = 2'd0;
    #1;
    checks++; if (num_free !== 7'd29) begin errors++;
      $display("FAIL alloc_free: got %0d expected 29", num_free); end
  endtask

  task automatic test_empty();
    // Regs 35..61 in nine triples leave two free.
    for (int c = 0; c < 9; c++) begin
      num_requested = 2'd3;
      #1;
      checks++; if (regs_to_use[0] !== 6'(35 + 3 * c)) begin errors++;
        $display("FAIL drain_reg c%0d: got %0d expected %0d", c, regs_to_use[0], 35 + 3 * c); end
      tick();
    end
    num_requested = 2'd1;
    tick();
    num_requested = 2'd3;
    #1;
    checks++; if (num_free !== 7'd1) begin errors++;
      $display("FAIL drain_free: got %0d expected 1", num_free); end
    checks++; if (num_granted !== 2'd1) begin errors++;
      $display("FAIL lastone_grant: got %0d expected 1", num_granted); end
    checks++; if (regs_to_use[0] !== 6'd63) begin errors++;
      $display("FAIL lastone_reg: got %0d expected 63", regs_to_use[0]); end
    tick();
    set_in(2'd2, 3'b001, 6'd5, 6'd0, 6'd0);
    #1;
    checks++; if (num_granted !== 2'd0) begin errors++;
      $display("FAIL empty_nobypass: got %0d expected 0", num_granted); end
    tick();
    set_in(2'd1, 3'b000, 6'd0, 6'd0, 6'd0);
    #1;
    checks++; if (num_free !== 7'd1) begin errors++;
      $display("FAIL empty_free_landed: got %0d expected 1", num_free); end
    checks++; if (num_granted !== 2'd1 || regs_to_use[0] !== 6'd5) begin errors++;
      $display("FAIL empty_reuse: got grant %0d reg %0d expected grant 1 reg 5",
               num_granted, regs_to_use[0]); end
    tick();
    num_requested = 2'd0;
  endtask

  task automatic test_sparse_wrap();
    int q[$];
    int v = 0;
    int exp_g;
    logic [2:0] rv;
    set_in(2'd0, 3'b101, 6'd7, 6'd11, 6'd9);
    tick();
    set_in(2'd3, 3'b000, 6'd0, 6'd0, 6'd0);
    #1;
    checks++; if (num_free !== 7'd2) begin errors++;
      $display("FAIL sparse_free: got %0d expected 2", num_free); end
    checks++; if (num_granted !== 2'd2 || regs_to_use[0] !== 6'd7 || regs_to_use[1] !== 6'd9)
    begin errors++;
      $display("FAIL sparse_order: got grant %0d regs %0d,%0d expected grant 2 regs 7,9",
               num_granted, regs_to_use[0], regs_to_use[1]); end
    tick();
    // Mixed traffic carries both pointers past the wrap.
    for (int c = 0; c < 70; c++) begin
      case (c % 3)
        0:       rv = 3'b011;
        1:       rv = 3'b101;
        default: rv = 3'b100;
      endcase
      set_in(2'(c % 4), rv, 6'(v), 6'(v + 1), 6'(v + 2));
      exp_g = ((c % 4) < q.size()) ? (c % 4) : q.size();
      #1;
      checks++; if (num_granted !== 2'(exp_g)) begin errors++;
        $display("FAIL wrap_grant c%0d: got %0d expected %0d", c, num_granted, exp_g); end
      for (int i = 0; i < exp_g; i++) begin
        checks++; if (regs_to_use[i] !== 6'(q[i])) begin errors++;
          $display("FAIL wrap_reg c%0d s%0d: got %0d expected %0d", c, i, regs_to_use[i], q[i]);
        end
      end
      tick();
      for (int i = 0; i < exp_g; i++) void'(q.pop_front());
      for (int s = 0; s < 3; s++) if (rv[s]) q.push_back((v + s) % 64);
      v += 3;
      set_in(2'd0, 3'b000, 6'd0, 6'd0, 6'd0);
      #1;
      checks++; if (num_free !== 7'(q.size())) begin errors++;
        $display("FAIL wrap_free c%0d: got %0d expected %0d", c, num_free, q.size()); end
    end
  endtask

  task automatic test_reset_midburst();
    set_in(2'd3, 3'b111, 6'd1, 6'd2, 6'd3);
    ckpt_save = 1'b1; ckpt_save_id = 2'd1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (num_granted !== 2'd0) begin errors++;
      $display("FAIL midrst_grant: got %0d expected 0", num_granted); end
    tick();
    reset = 1'b1;
    idle();
    #1;
    checks++; if (num_free !== 7'd32) begin errors++;
      $display("FAIL midrst_free: got %0d expected 32", num_free); end
    checks++; if (regs_to_use[0] !== 6'd32 || regs_to_use[1] !== 6'd33 || regs_to_use[2] !== 6'd34)
    begin errors++;
      $display("FAIL midrst_regs: got %0d,%0d,%0d expected 32,33,34",
               regs_to_use[0], regs_to_use[1], regs_to_use[2]); end
    // A cleared checkpoint points at head 0, so restoring it changes nothing.
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd1;
    tick();
    ckpt_restore = 1'b0;
    #1;
    checks++; if (num_free !== 7'd32 || regs_to_use[0] !== 6'd32) begin errors++;
      $display("FAIL midrst_ckpt: got free %0d reg %0d expected free 32 reg 32",
               num_free, regs_to_use[0]); end
  endtask

  task automatic test_ckpt();
    num_requested = 2'd3; tick();
    num_requested = 2'd3; tick();
    num_requested = 2'd2; tick();
    num_requested = 2'd2;
    ckpt_save = 1'b1; ckpt_save_id = 2'd2;
    #1;
    checks++; if (num_free !== 7'd24) begin errors++;
      $display("FAIL ckpt_presave_free: got %0d expected 24", num_free); end
    checks++; if (num_granted !== 2'd2 || regs_to_use[0] !== 6'd40 || regs_to_use[1] !== 6'd41)
    begin errors++;
      $display("FAIL ckpt_save_grant: got grant %0d regs %0d,%0d expected grant 2 regs 40,41",
               num_granted, regs_to_use[0], regs_to_use[1]); end
    tick();
    ckpt_save = 1'b0;
    num_requested = 2'd3; tick();
    num_requested = 2'd2; tick();
    set_in(2'd3, 3'b010, 6'd0, 6'd5, 6'd0);
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd2;
    #1;
    checks++; if (num_granted !== 2'd0) begin errors++;
      $display("FAIL ckpt_restore_grant: got %0d expected 0", num_granted); end
    tick();
    idle();
    num_requested = 2'd1;
    #1;
    checks++; if (num_free !== 7'd23) begin errors++;
      $display("FAIL ckpt_restore_free: got %0d expected 23", num_free); end
    checks++; if (num_granted !== 2'd1 || regs_to_use[0] !== 6'd42) begin errors++;
      $display("FAIL ckpt_reissue: got grant %0d reg %0d expected grant 1 reg 42",
               num_granted, regs_to_use[0]); end
    num_requested = 2'd0;
  endtask

  task automatic test_save_restore_same_cycle();
    // Head is 10; slot 3 takes 13, then head advances to 15.
    num_requested = 2'd3;
    ckpt_save = 1'b1; ckpt_save_id = 2'd3;
    tick();
    ckpt_save = 1'b0;
    num_requested = 2'd2;
    tick();
    num_requested = 2'd3;
    ckpt_save = 1'b1; ckpt_save_id = 2'd3;
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd2;
    #1;
    checks++; if (num_granted !== 2'd0) begin errors++;
      $display("FAIL both_grant: got %0d expected 0", num_granted); end
    tick();
    idle();
    #1;
    checks++; if (num_free !== 7'd23 || regs_to_use[0] !== 6'd42) begin errors++;
      $display("FAIL both_restore: got free %0d reg %0d expected free 23 reg 42",
               num_free, regs_to_use[0]); end
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd3;
    tick();
    ckpt_restore = 1'b0;
    #1;
    checks++; if (num_free !== 7'd20 || regs_to_use[0] !== 6'd45) begin errors++;
      $display("FAIL both_slot_kept: got free %0d reg %0d expected free 20 reg 45",
               num_free, regs_to_use[0]); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_empty();
    test_sparse_wrap();
    test_reset_midburst();
    test_ckpt();
    test_save_restore_same_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
